// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and fills the IF/ID register.
// Optional IF_BOUNDS_CHECK_EN adds a sticky FAULT state for out-of-range or misaligned fetches.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_data,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_if_id_valid,
  output logic [31:0] o_if_id_instr,
  output logic [31:0] o_if_id_pc,
  output logic [31:0] o_if_id_pc4,
  output logic [31:0] o_fetch_count,
  output logic        o_fault
);

  typedef enum logic {S_RUN, S_FAULT} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_ifpc;
  logic [31:0] r_ifpc4;
  logic [31:0] r_count;

  logic [31:0] w_pc_next;
  logic        w_valid_next;
  logic [31:0] w_instr_next;
  logic [31:0] w_ifpc_next;
  logic [31:0] w_ifpc4_next;
  logic [31:0] w_count_next;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = {i_redirect_pc[31:2], 2'b00};

`ifdef IF_BOUNDS_CHECK_EN
  localparam logic [32:0] ROM_BYTES = 33'(64'd4 << ADDR_WIDTH);
  logic w_adv_oob;
  logic w_redir_bad;
  // Widened compares so an in-range limit of 2^32 bytes still works.
  assign w_adv_oob   = {1'b0, w_pc_plus4} >= ROM_BYTES;
  assign w_redir_bad = (i_redirect_pc[1:0] != 2'b00) || ({1'b0, i_redirect_pc} >= ROM_BYTES);
`endif

  // State and pipeline registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
      r_instr <= 32'd0;
      r_ifpc  <= 32'd0;
      r_ifpc4 <= 32'd0;
      r_count <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_valid <= w_valid_next;
      r_instr <= w_instr_next;
      r_ifpc  <= w_ifpc_next;
      r_ifpc4 <= w_ifpc4_next;
      r_count <= w_count_next;
    end
  end

  // Next-state: redirect beats stall beats advance; FAULT holds everything but valid.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_valid_next = r_valid;
    w_instr_next = r_instr;
    w_ifpc_next  = r_ifpc;
    w_ifpc4_next = r_ifpc4;
    w_count_next = r_count;
    case (r_state)
      S_RUN: begin
        if (i_redirect_valid) begin
          w_valid_next = 1'b0;
`ifdef IF_BOUNDS_CHECK_EN
          if (w_redir_bad) begin
            w_state_next = S_FAULT;
          end else begin
            w_pc_next    = w_target;
            w_instr_next = 32'd0;
          end
`else
          w_pc_next    = w_target;
          w_instr_next = 32'd0;
`endif
        end else if (!i_stall) begin
`ifdef IF_BOUNDS_CHECK_EN
          if (w_adv_oob) begin
            w_state_next = S_FAULT;
            w_valid_next = 1'b0;
          end else begin
            w_pc_next    = w_pc_plus4;
            w_valid_next = 1'b1;
            w_instr_next = i_imem_data;
            w_ifpc_next  = r_pc;
            w_ifpc4_next = w_pc_plus4;
            w_count_next = r_count + 32'd1;
          end
`else
          w_pc_next    = w_pc_plus4;
          w_valid_next = 1'b1;
          w_instr_next = i_imem_data;
          w_ifpc_next  = r_pc;
          w_ifpc4_next = w_pc_plus4;
          w_count_next = r_count + 32'd1;
`endif
        end
      end
      S_FAULT: begin
        w_valid_next = 1'b0;
      end
      default: begin
        w_state_next = S_RUN;
      end
    endcase
  end

`ifdef IF_BOUNDS_CHECK_EN
  logic r_fault;
  always_ff @(posedge i_clock) begin
    if (i_reset) r_fault <= 1'b0;
    else         r_fault <= (w_state_next == S_FAULT);
  end
  assign o_fault = r_fault;
`else
  assign o_fault = 1'b0;
`endif

  assign o_imem_addr   = r_pc;
  assign o_if_id_valid = r_valid;
  assign o_if_id_instr = r_instr;
  assign o_if_id_pc    = r_ifpc;
  assign o_if_id_pc4   = r_ifpc4;
  assign o_fetch_count = r_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a 1024-word ROM model; expectations follow the macro setting.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] fetch_count;
  logic        fault;

  logic [31:0] rom [1024];
  int checks   = 0;
  int failures = 0;

  if_stage #(.RESET_PC(32'h0000_0000), .ADDR_WIDTH(10)) dut (
    .i_clock          (clk),
    .i_reset          (reset),
    .o_imem_addr      (imem_addr),
    .i_imem_data      (imem_data),
    .i_stall          (stall),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_if_id_valid    (if_id_valid),
    .o_if_id_instr    (if_id_instr),
    .o_if_id_pc       (if_id_pc),
    .o_if_id_pc4      (if_id_pc4),
    .o_fetch_count    (fetch_count),
    .o_fault          (fault)
  );

  always #5 clk = ~clk;

  assign imem_data = rom[imem_addr[11:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".valid"}, 32'(if_id_valid), 32'd0);
    chk({tag, ".instr"}, if_id_instr, 32'd0);
    chk({tag, ".pc"},    if_id_pc, 32'd0);
    chk({tag, ".pc4"},   if_id_pc4, 32'd0);
    chk({tag, ".count"}, fetch_count, 32'd0);
    chk({tag, ".addr"},  imem_addr, 32'd0);
    chk({tag, ".fault"}, 32'(fault), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'hA500_0000 | 32'(i);
    rom[0] = 32'h200a0040;
    rom[1] = 32'h014a5020;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    step(); step();
    chk_reset_vals("rst");

    // Two back-to-back fetches.
    reset = 1'b0;
    step();
    chk("f1.valid", 32'(if_id_valid), 32'd1);
    chk("f1.instr", if_id_instr, 32'h200a0040);
    chk("f1.pc",    if_id_pc, 32'h0);
    chk("f1.pc4",   if_id_pc4, 32'h4);
    chk("f1.addr",  imem_addr, 32'h4);
    step();
    chk("f2.instr", if_id_instr, 32'h014a5020);
    chk("f2.pc",    if_id_pc, 32'h4);
    chk("f2.count", fetch_count, 32'd2);

    // Three-cycle stall holds IF/ID and the PC.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stl.pc",    if_id_pc, 32'h4);
      chk("stl.instr", if_id_instr, 32'h014a5020);
      chk("stl.addr",  imem_addr, 32'h8);
      chk("stl.count", fetch_count, 32'd2);
    end
    stall = 1'b0;
    step();
    chk("rel.pc",    if_id_pc, 32'h8);
    chk("rel.instr", if_id_instr, 32'hA500_0002);
    chk("rel.count", fetch_count, 32'd3);

    // Redirect while stalled squashes and retargets.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    chk("rd.valid", 32'(if_id_valid), 32'd0);
    chk("rd.addr",  imem_addr, 32'h40);
    chk("rd.instr", if_id_instr, 32'd0);
    chk("rd.pc",    if_id_pc, 32'h8);
    chk("rd.count", fetch_count, 32'd3);
    stall = 1'b0; redirect_valid = 1'b0;
    step();
    chk("rd2.valid", 32'(if_id_valid), 32'd1);
    chk("rd2.pc",    if_id_pc, 32'h40);
    chk("rd2.instr", if_id_instr, 32'hA500_0010);
    chk("rd2.count", fetch_count, 32'd4);

    // Misaligned redirect.
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    step();
    redirect_valid = 1'b0;
`ifdef IF_BOUNDS_CHECK_EN
    chk("mis.fault", 32'(fault), 32'd1);
    chk("mis.valid", 32'(if_id_valid), 32'd0);
    chk("mis.addr",  imem_addr, 32'h44);
    step();
    chk("mis2.fault", 32'(fault), 32'd1);
    chk("mis2.valid", 32'(if_id_valid), 32'd0);
    chk("mis2.count", fetch_count, 32'd4);
`else
    chk("mis.addr",  imem_addr, 32'h40);
    chk("mis.valid", 32'(if_id_valid), 32'd0);
    chk("mis.fault", 32'(fault), 32'd0);
    step();
    chk("mis2.pc", if_id_pc, 32'h40);
    chk("mis2.count", fetch_count, 32'd5);
`endif

    // Reset recovers from any state.
    reset = 1'b1;
    step();
    chk_reset_vals("rst2");
    reset = 1'b0;

    // Top of ROM.
    redirect_valid = 1'b1; redirect_pc = 32'hFF8;
    step();
    redirect_valid = 1'b0;
    chk("top.addr", imem_addr, 32'hFF8);
    step();
    chk("top.pc",    if_id_pc, 32'hFF8);
    chk("top.instr", if_id_instr, 32'hA500_03FE);
    chk("top.addr2", imem_addr, 32'hFFC);
    step();
`ifdef IF_BOUNDS_CHECK_EN
    chk("oob.fault", 32'(fault), 32'd1);
    chk("oob.valid", 32'(if_id_valid), 32'd0);
    chk("oob.addr",  imem_addr, 32'hFFC);
    chk("oob.count", fetch_count, 32'd1);
`else
    chk("wrap.pc",    if_id_pc, 32'hFFC);
    chk("wrap.instr", if_id_instr, 32'hA500_03FF);
    chk("wrap.addr",  imem_addr, 32'h1000);
    step();
    chk("wrap2.pc",    if_id_pc, 32'h1000);
    chk("wrap2.instr", if_id_instr, 32'h200a0040);
    chk("wrap2.count", fetch_count, 32'd3);
`endif

    // Reset mid-stall and together with a redirect.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    stall = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk_reset_vals("rst_stall");
    stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    chk_reset_vals("rst_redir");
    reset = 1'b0; redirect_valid = 1'b0;
    step();
    chk("post.pc", if_id_pc, 32'h0);
    chk("post.valid", 32'(if_id_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the single-cycle/pipelined MIPS core. It owns the program counter, drives the word address into the combinational instruction ROM, and captures the returned instruction in the IF/ID pipeline register. It handles the stall, redirect (branch/jump) and squash rules, and optionally flags out-of-range fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_WIDTH, 10, ROM word-index width. ROM size is 4·2^ADDR_WIDTH bytes.
- clock  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- imem_addr  out  32  byte address to ROM; equals current PC, combinational from PC register.
- imem_data  in  32  instruction word from ROM, already endian-corrected, valid in the same cycle.
- stall  in  1  downstream hazard; hold PC and IF/ID.
- redirect_valid  in  1  taken branch/jump; load redirect_pc.
- redirect_pc  in  32  target byte address.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  32  captured instruction.
- if_id_pc  out  32  address of captured instruction.
- if_id_pc4  out  32  if_id_pc + 4.
- fetch_count  out  32  number of instructions accepted into IF/ID, modulo 2^32.
- fault  out  1  sticky out-of-range/misaligned fetch flag (only with the macro; tied 0 otherwise).

## Operation
- States: RUN, FAULT. FAULT exists only with IF_BOUNDS_CHECK_EN.
- RUN priority per cycle: reset > redirect_valid > stall > advance.
- Advance: PC <= PC+4 (32-bit, wraps); IF/ID <= {1, imem_data, PC, PC+4}; fetch_count++.
- Stall (no redirect): PC, IF/ID, fetch_count hold.
- Redirect (overrides stall): PC <= {redirect_pc[31:2], 2'b00}; if_id_valid <= 0 (squash wrong-path fetch). if_id_instr <= 0, if_id_pc/pc4 hold. fetch_count holds.
- Without the macro, only word index PC[ADDR_WIDTH+1:2] is meaningful to the ROM. Higher PC bits are ignored, so fetch wraps modulo ROM size.
- FAULT: PC, IF/ID contents hold; if_id_valid = 0; fault = 1. Only reset exits.

## Timing
- Reset values: PC = RESET_PC, imem_addr = RESET_PC, if_id_valid = 0, if_id_instr = 0, if_id_pc = 0, if_id_pc4 = 0, fetch_count = 0, fault = 0, state = RUN.
- Fetch latency: 1 cycle. Word at imem_addr in cycle N appears on if_id_* after edge N.
- First valid instruction appears after the first edge with reset low.
- Redirect in cycle N: imem_addr = target in cycle N+1; if_id_valid = 0 in cycle N+1; target instruction valid in N+2.
- Stall asserted for k cycles: IF/ID is stable for k cycles; no instruction is lost or duplicated.
- Reset asserted mid-stall, mid-redirect or in FAULT wins at that edge.

## Configuration
- IF_BOUNDS_CHECK_EN defined:
  - If an advance produces PC+4 ≥ 4·2^ADDR_WIDTH, the stage enters FAULT instead of loading it.
  - If a redirect has redirect_pc[1:0] ≠ 0 or redirect_pc ≥ 4·2^ADDR_WIDTH, the stage enters FAULT instead of loading it.
  - The instruction fetched in that cycle is not accepted.
- IF_BOUNDS_CHECK_EN undefined:
  - No FAULT state; fault is tied 0.
  - Misaligned targets are truncated to the word boundary.
  - PC increments freely; ROM indexing wraps.

## Test plan
- Reset with RESET_PC=0, ROM[0]=32'h200a0040, ROM[1]=32'h014a5020, no stall → cycle 1: if_id_valid=1, instr=32'h200a0040, pc=0, pc4=4; cycle 2: instr=32'h014a5020, pc=4; fetch_count=2.
- Stall high for 3 cycles after pc=4 captured → IF/ID stays pc=4 and imem_addr stays 8 for 3 cycles; after release, next if_id_pc=8 with no duplicate; fetch_count increments by 1.
- Redirect to 32'h40 while stall=1 → next cycle if_id_valid=0, imem_addr=32'h40; following cycle if_id_pc=32'h40, valid=1.
- Redirect to 32'h43 → with macro: fault=1, if_id_valid=0 thereafter; without macro: imem_addr=32'h40.
- ADDR_WIDTH=10, run to PC=32'hFFC → with macro: fault at the next advance, PC holds 32'hFFC; without macro: imem_addr=32'h1000 and the ROM returns word 0.
- Assert reset while in FAULT or mid-stall → next cycle all outputs at reset values, PC=RESET_PC.
